// File: rtl/serial_rx_slave.sv
// serial_rx_slave: oversampled SPI-style slave, MSB-first frames to a parallel word with Valid/FrameErr strobes.
// Define SERIAL_RX_ECHO_EN to add MISO, which echoes the previous good word during the next frame.
module serial_rx_slave #(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ss,
  input  logic             sclk,
  input  logic             mosi,
`ifdef SERIAL_RX_ECHO_EN
  output logic             miso,
`endif
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_err,
  output logic             busy,
  output logic [2:0]       current_state_out
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {
    IDLE = 3'd0, SHIFT = 3'd1, FULL = 3'd2, COMMIT = 3'd3, ERR = 3'd4, ARM = 3'd5
  } state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] ss_sy, sclk_sy, mosi_sy;
  logic ss_q, sclk_q, ss_s, mosi_s, ss_rise, ss_fall, sclk_rise;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic ovr, ovr_nx;
  // Synchronizers reset low so ARM waits for a genuinely high SS after reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ss_sy <= '0;
      sclk_sy <= '0;
      mosi_sy <= '0;
      ss_q <= 1'b0;
      sclk_q <= 1'b0;
    end else begin
      ss_sy <= {ss_sy[SYNC_STAGES-2:0], ss};
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], mosi};
      ss_q <= ss_s;
      sclk_q <= sclk_sy[SYNC_STAGES-1];
    end
  assign ss_s = ss_sy[SYNC_STAGES-1];
  assign mosi_s = mosi_sy[SYNC_STAGES-1];
  assign ss_rise = ss_s & ~ss_q;
  assign ss_fall = ~ss_s & ss_q;
  assign sclk_rise = sclk_sy[SYNC_STAGES-1] & ~sclk_q;
  // A bit arriving with the SS rise is counted before the frame end is judged.
  always_comb begin
    state_nx = state;
    sr_nx = sr;
    cnt_nx = cnt;
    ovr_nx = ovr;
    case (state)
      ARM: state_nx = ss_s ? IDLE : ARM;
      IDLE: if (ss_fall) begin
        sr_nx = '0;
        cnt_nx = '0;
        ovr_nx = 1'b0;
        state_nx = SHIFT;
      end
      SHIFT: begin
        if (sclk_rise) begin
          sr_nx = {sr[WIDTH-2:0], mosi_s};
          cnt_nx = cnt + CW'(1);
        end
        if (cnt_nx == CW'(WIDTH)) state_nx = ss_rise ? COMMIT : FULL;
        else if (ss_rise) state_nx = ERR;
      end
      FULL: begin
        ovr_nx = ovr | sclk_rise;
        state_nx = ss_rise ? COMMIT : FULL;
      end
      COMMIT, ERR: state_nx = IDLE;
      default: state_nx = ARM;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARM;
      current_state_out <= 3'd0;
      sr <= '0;
      cnt <= '0;
      ovr <= 1'b0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nx;
      current_state_out <= state_nx;
      sr <= sr_nx;
      cnt <= cnt_nx;
      ovr <= ovr_nx;
      valid <= state == COMMIT && !ovr;
      frame_err <= state == ERR || (state == COMMIT && ovr);
      if (state == COMMIT && !ovr) data <= sr;
    end
  assign busy = state == SHIFT || state == FULL;
`ifdef SERIAL_RX_ECHO_EN
  logic [WIDTH-1:0] tx;
  logic sclk_fall;
  assign sclk_fall = ~sclk_sy[SYNC_STAGES-1] & sclk_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tx <= '0;
    else if (ss_fall) tx <= data;
    else if (sclk_fall && !ss_s) tx <= {tx[WIDTH-2:0], 1'b0};
  assign miso = ~ss_s & tx[WIDTH-1];
`endif
endmodule

// File: tb/tb_serial_rx_slave.sv
// tb_serial_rx_slave: random and directed frames checked every cycle against a frame-level reference model.
module tb_serial_rx_slave;
  localparam int WIDTH = 32;
  localparam int SYNC = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic [WIDTH-1:0] data;
  logic valid, frame_err, busy;
  logic [2:0] cso;
`ifdef SERIAL_RX_ECHO_EN
  logic miso;
`endif
  int n_chk = 0, n_fail = 0;
  longint cyc = 0, pend_cyc = -1;
  logic pend_good = 1'b0;
  logic [WIDTH-1:0] pend_word = '0, mdl_data = '0;
  bit chk_en = 1'b0;

  serial_rx_slave #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ss(ss), .sclk(sclk), .mosi(mosi),
`ifdef SERIAL_RX_ECHO_EN
    .miso(miso),
`endif
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy),
    .current_state_out(cso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Strobes are expected exactly SYNC+2 clocks after the edge where SS goes high.
  always @(negedge clk) if (chk_en) begin
    if (cyc == pend_cyc && pend_good) mdl_data = pend_word;
    chk("valid", valid, cyc == pend_cyc && pend_good);
    chk("frame_err", frame_err, cyc == pend_cyc && !pend_good);
    chk("data", data, mdl_data);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic raise(input int nb, input logic [WIDTH+7:0] w, input bit track);
    ss = 1'b1;
    if (track) begin
      pend_good = nb == WIDTH;
      pend_word = w[WIDTH-1:0];
      pend_cyc = cyc + SYNC + 2;
    end
  endtask

  task automatic clock_bit(input logic b, input int hp);
    mosi = b;
    tick(hp);
    sclk = 1'b1;
    tick(hp);
    sclk = 1'b0;
  endtask

  task automatic send(input int nb, input logic [WIDTH+7:0] w, input int hp, input bit same);
    logic [WIDTH-1:0] prev, echo;
    prev = mdl_data;
    echo = '0;
    ss = 1'b0;
    tick(hp);
    for (int i = nb - 1; i >= 0; i--) begin
      mosi = w[i];
      tick(hp);
`ifdef SERIAL_RX_ECHO_EN
      echo = {echo[WIDTH-2:0], miso};
`endif
      sclk = 1'b1;
      if (same && i == 0) raise(nb, w, 1'b1);
      tick(hp);
      sclk = 1'b0;
    end
    tick(hp);
    if (!same) raise(nb, w, 1'b1);
    tick(hp + 4);
`ifdef SERIAL_RX_ECHO_EN
    if (nb == WIDTH) chk("miso_echo", echo, prev);
`else
    if (echo != prev) echo = prev;
`endif
  endtask

  initial begin
    int nb, hp;
    logic [WIDTH+7:0] w;
    tick(2);
    chk("rst_state", 32'(cso), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    tick(1);
    chk("arm_state", 32'(cso), 32'd5);
    tick(4);
    chk("idle_state", 32'(cso), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk_en = 1'b1;

    send(32, 40'hA5C30F81, 8, 1'b0);
    chk("frame1_data", data, 32'hA5C30F81);
    send(31, 40'h12345678, 4, 1'b0);
    chk("short_keeps", data, 32'hA5C30F81);
    send(33, 40'h1FFFFFFFF, 4, 1'b0);
    chk("long_keeps", data, 32'hA5C30F81);
    send(32, 40'h1, 3, 1'b0);
    chk("one_data", data, 32'h1);

    ss = 1'b0;
    tick(4);
    for (int i = 0; i < 12; i++) clock_bit(i[0], 3);
    chk("mid_busy", 32'(busy), 32'd1);
    chk_en = 1'b0;
    #1 rst_n = 1'b0;
    mdl_data = '0;
    pend_cyc = -1;
    #1;
    chk("async_data", data, 32'd0);
    chk("async_state", 32'(cso), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    tick(2);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    tick(3);
    chk("rearm_state", 32'(cso), 32'd5);
    for (int i = 0; i < 20; i++) clock_bit(1'b1, 3);
    tick(3);
    raise(0, '0, 1'b0);
    tick(8);
    chk("post_arm_idle", 32'(cso), 32'd0);
    send(32, 40'hFFFFFFFF, 4, 1'b0);
    chk("ones_data", data, 32'hFFFFFFFF);

    send(32, 40'h12345678, 4, 1'b0);
    send(32, 40'hDEADBEEF, 4, 1'b0);
    chk("beef_data", data, 32'hDEADBEEF);
    send(32, 40'h0BADF00D, 3, 1'b1);
    chk("same_edge_good", data, 32'h0BADF00D);
    send(31, 40'h7, 3, 1'b1);
    chk("same_edge_short", data, 32'h0BADF00D);

    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 3))
        0: nb = WIDTH;
        1: nb = WIDTH - 1;
        2: nb = WIDTH + 1;
        default: nb = $urandom_range(1, WIDTH + 3);
      endcase
      w = {$urandom, $urandom};
      hp = $urandom_range(3, 6);
      send(nb, w, hp, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_rx_slave.md
# serial_rx_slave

Receive-side counterpart of the SerialCTL shifter: a single-clock SPI-style slave that captures MSB-first frames from SS/SCLK/MOSI and presents each complete word on a parallel bus with a one-cycle strobe. SS, SCLK and MOSI are asynchronous to Clock and oversampled. The block sits at the far end of the serial link, for example in the loopback harness or in the target FPGA, and feeds the counter/control logic.

## Interface
- WIDTH, 32: frame length in bits; Data width.
- SYNC_STAGES, 2: synchronizer flops on SS, SCLK and MOSI (≥2).
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low; clears all state immediately.
- SS  in  1  frame select, active-low, asynchronous.
- SCLK  in  1  serial clock, idle low; MOSI is sampled on the synchronized rising edge.
- MOSI  in  1  serial data, MSB first.
- Data  out  WIDTH  last good word; reset 0; changes only with Valid.
- Valid  out  1  one-cycle strobe, good frame committed; reset 0.
- FrameErr  out  1  one-cycle strobe, frame ended with bit count ≠ WIDTH; reset 0.
- Busy  out  1  high while a frame is in progress (SHIFT/FULL); reset 0.
- CurrentStateOut  out  3  debug state code; reset 0 (IDLE).

## Operation
- Inputs pass through SYNC_STAGES flops, plus one history flop each on SS and SCLK for edge detection.
- States: IDLE=0, SHIFT=1, FULL=2, COMMIT=3, ERR=4, ARM=5.
- ARM: entered on reset release. Leaves for IDLE only after synchronized SS has been high. This ensures a frame already in flight at reset is never captured.
- IDLE: on synchronized SS falling edge, clear the shift register and bit counter, then go to SHIFT.
- SHIFT: each synchronized SCLK rising edge shifts in the synchronized MOSI: sr <= {sr[WIDTH-2:0], mosi}. The counter increments. On the WIDTH-th bit, go to FULL.
- FULL: wait for SS rising edge, then go to COMMIT. A further SCLK rising edge in FULL is an overrun: set the overrun flag, and the shift register is not modified.
- COMMIT: one cycle; Data <= sr, Valid=1, or FrameErr=1 instead if overrun is set; then IDLE.
- SS rising edge in SHIFT (short frame): go to ERR. ERR is one cycle with FrameErr=1 and Data unchanged, then IDLE.
- SCLK rising edge and SS rising edge detected in the same cycle: the bit is shifted and counted first, then the frame end is evaluated. Exactly WIDTH bits under this rule is a good frame.
- SCLK edges while SS is high are ignored.
- Counter width is clog2(WIDTH+1). It saturates at WIDTH.

## Timing
- Input change sampled at Clock edge k is visible to the FSM at edge k+SYNC_STAGES.
- Valid/FrameErr are high during cycle k+SYNC_STAGES+2 after the Clock edge k that first samples SS high. With defaults this is 4 cycles.
- Data is valid in the same cycle as Valid and holds until the next Valid.
- Minimum SCLK high and low time: 2 Clock periods.
- Minimum SS high time between frames: 3 Clock periods.
- MOSI must be stable from 1 Clock period before until 2 Clock periods after each SCLK rising edge.
- Reset low mid-frame: outputs return to reset values asynchronously and the state goes to ARM. The partial frame is discarded with no FrameErr.

## Configuration
- SERIAL_RX_ECHO_EN defined:
  - Adds output MISO (1 bit, reset 0).
  - On SS falling edge, a transmit register loads the previous good Data.
  - MISO presents the transmit MSB and shifts on each synchronized SCLK falling edge, giving a full-duplex echo of the prior word.
  - MISO holds 0 while SS is high.
- Undefined: no MISO port and no transmit register. Behaviour is otherwise identical.

## Test plan
- Reset low, then high, with SS=1 → state ARM then IDLE; Data=0, Valid=0, FrameErr=0, Busy=0.
- Frame 0xA5C3_0F81, SCLK half-period 8 Clocks → Valid for exactly 1 cycle, 4 cycles after SS rises; Data=0xA5C30F81; FrameErr=0.
- Frame of 31 bits → FrameErr for 1 cycle; Data keeps 0xA5C30F81; Valid stays 0.
- Frame of 33 bits → FrameErr for 1 cycle; Data unchanged. A following good frame of 0x0000_0001 → Valid, Data=1.
- Reset asserted after bit 12 of a frame with SS held low through release → no Valid or FrameErr for that frame. The next frame 0xFFFF_FFFF → Data=0xFFFFFFFF.
- With SERIAL_RX_ECHO_EN: send 0x1234_5678, then 0xDEAD_BEEF → MISO bits during the second frame read 0x12345678, MSB first.
